free_list_ckpt: RTL

- Parametrised circular free list of physical register tags for the rename stage.
- Grants up to ALLOC_WIDTH destination tags per cycle and accepts up to FREE_WIDTH retired tags per cycle.
- Holds an in-order ring of NUM_CKPTS branch checkpoints internally. A checkpoint stores only the head pointer, so misprediction recovery rewinds the head in one cycle without copying the list.

---
 rtl/free_list_pkg.sv | 47 ++++
 rtl/free_list_ckpt_ring.sv | 96 +++++++++
 rtl/free_list_ckpt.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// -----------------------------------------------------------------------------
// free_list_pkg
// Shared definitions for the checkpointed physical-register free list.
//   - Default configuration constants (FL_*) used as parameter defaults.
//   - Derived widths for the default configuration: PTR_W (pointer with wrap
//     bit), TAG_W (physical tag), CKPT_W (checkpoint id).
//   - ptr_t / ckpt_snap_t typedefs for the default configuration.
//   - count_below(): number of set bits of vec at positions below lim. It is
//     used for plain popcount (lim = vector width) and for lane compaction
//     (lim = lane index).
// -----------------------------------------------------------------------------
package free_list_pkg;

   localparam int unsigned FL_NUM_PHYS_REGS = 64;
   localparam int unsigned FL_NUM_ARCH_REGS = 32;
   localparam int unsigned FL_ALLOC_WIDTH   = 2;
   localparam int unsigned FL_FREE_WIDTH    = 2;
   localparam int unsigned FL_NUM_CKPTS     = 4;
   localparam int unsigned FL_DEPTH         = FL_NUM_PHYS_REGS - FL_NUM_ARCH_REGS;

   localparam int unsigned PTR_W  = $clog2(FL_DEPTH) + 1;
   localparam int unsigned TAG_W  = $clog2(FL_NUM_PHYS_REGS);
   localparam int unsigned CKPT_W = $clog2(FL_NUM_CKPTS);

   typedef logic [PTR_W-1:0] ptr_t;

   typedef struct packed {
      ptr_t head;
   } ckpt_snap_t;

   localparam int unsigned CNT_W = 8;

   function automatic logic [CNT_W-1:0] count_below(input logic [31:0] vec,
                                                    input int unsigned lim);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((i < lim) && vec[i]) begin
            cnt = cnt + 8'd1;
         end else begin
            cnt = cnt;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/free_list_ckpt_ring.sv
// -----------------------------------------------------------------------------
// free_list_ckpt_ring
// In-order ring of branch checkpoints. Each slot holds the free-list head
// pointer to restore on a misprediction.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   make          : allocate a slot at ckpt_tail and store make_snap
//   commit        : release the oldest slot (ignored when the ring is empty)
//   recall        : drop every checkpoint younger than recall_id
//   recall_id     : checkpoint being restored
//   make_snap     : head pointer to store
//   ckpt_id       : slot index the next make will use
//   ckpt_full     : all slots in use
//   recall_snap   : stored head pointer of slot recall_id
// -----------------------------------------------------------------------------
module free_list_ckpt_ring
   import free_list_pkg::*;
#(
   parameter int unsigned NUM_CKPTS = FL_NUM_CKPTS,
   parameter int unsigned SNAP_W    = PTR_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          make,
   input  logic                          commit,
   input  logic                          recall,
   input  logic [$clog2(NUM_CKPTS)-1:0]  recall_id,
   input  logic [SNAP_W-1:0]             make_snap,
   output logic [$clog2(NUM_CKPTS)-1:0]  ckpt_id,
   output logic                          ckpt_full,
   output logic [SNAP_W-1:0]             recall_snap
);

   localparam int unsigned C_W      = $clog2(NUM_CKPTS);
   localparam logic [C_W:0] PTR_ONE  = (C_W+1)'(1);
   localparam logic [C_W:0] FULL_CNT = (C_W+1)'(NUM_CKPTS);

   logic [C_W:0]        ckpt_head_q, ckpt_head_d;
   logic [C_W:0]        ckpt_tail_q, ckpt_tail_d;
   logic [SNAP_W-1:0]   snap_q [NUM_CKPTS];
   logic [SNAP_W-1:0]   snap_d [NUM_CKPTS];
   logic [C_W:0]        ring_cnt;
   logic                ring_empty;
   logic [C_W-1:0]      recall_off;

   // Ring occupancy, status outputs and next-state pointers.
   always_comb begin
      ring_cnt    = ckpt_tail_q - ckpt_head_q;
      ring_empty  = (ring_cnt == '0);
      ckpt_full   = (ring_cnt == FULL_CNT);
      ckpt_id     = ckpt_tail_q[C_W-1:0];
      recall_snap = snap_q[recall_id];
      // recall_id has no wrap bit; rebuild the pointer from its age relative to the oldest slot.
      recall_off  = recall_id - ckpt_head_q[C_W-1:0];

      if (commit && !ring_empty) begin
         ckpt_head_d = ckpt_head_q + PTR_ONE;
      end else begin
         ckpt_head_d = ckpt_head_q;
      end

      if (recall) begin
         ckpt_tail_d = ckpt_head_q + {1'b0, recall_off} + PTR_ONE;
      end else if (make) begin
         ckpt_tail_d = ckpt_tail_q + PTR_ONE;
      end else begin
         ckpt_tail_d = ckpt_tail_q;
      end
   end

   // Snapshot write for an accepted make.
   always_comb begin
      snap_d = snap_q;
      if (make) begin
         snap_d[ckpt_tail_q[C_W-1:0]] = make_snap;
      end else begin
         snap_d = snap_q;
      end
   end

   // Ring state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ckpt_head_q <= '0;
         ckpt_tail_q <= '0;
         for (int i = 0; i < NUM_CKPTS; i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         ckpt_head_q <= ckpt_head_d;
         ckpt_tail_q <= ckpt_tail_d;
         snap_q      <= snap_d;
      end
   end

endmodule

// File: rtl/free_list_ckpt.sv
// -----------------------------------------------------------------------------
// free_list_ckpt
// Circular free list of physical register tags for rename, with head-pointer
// branch checkpoints for single-cycle misprediction recovery.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   alloc_req/ready/tags  : per-lane tag requests, all-or-nothing grant, tags
//   free_valid/free_tags  : retired tags returned to the tail (compacted)
//   ckpt_make/ckpt_lane   : take a checkpoint after the branch in lane ckpt_lane
//   ckpt_id/ckpt_full     : id of the checkpoint being made, ring full
//   ckpt_commit           : release oldest checkpoint
//   recall_valid/recall_id: restore head from a checkpoint
//   free_count            : number of free tags
//   dbl_free_err          : sticky double-free / overflow error (only with
//                           FREE_LIST_DOUBLE_FREE_CHECK_EN defined)
// Optional feature macro: FREE_LIST_DOUBLE_FREE_CHECK_EN
// -----------------------------------------------------------------------------
module free_list_ckpt
   import free_list_pkg::*;
#(
   parameter int unsigned NUM_PHYS_REGS = FL_NUM_PHYS_REGS,
   parameter int unsigned NUM_ARCH_REGS = FL_NUM_ARCH_REGS,
   parameter int unsigned ALLOC_WIDTH   = FL_ALLOC_WIDTH,
   parameter int unsigned FREE_WIDTH    = FL_FREE_WIDTH,
   parameter int unsigned NUM_CKPTS     = FL_NUM_CKPTS
) (
   input  logic                                                   clk,
   input  logic                                                   reset,
   input  logic [ALLOC_WIDTH-1:0]                                 alloc_req,
   output logic                                                   alloc_ready,
   output logic [ALLOC_WIDTH-1:0][$clog2(NUM_PHYS_REGS)-1:0]      alloc_tags,
   input  logic [FREE_WIDTH-1:0]                                  free_valid,
   input  logic [FREE_WIDTH-1:0][$clog2(NUM_PHYS_REGS)-1:0]       free_tags,
   input  logic                                                   ckpt_make,
   input  logic [((ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH) : 1)-1:0] ckpt_lane,
   output logic [$clog2(NUM_CKPTS)-1:0]                           ckpt_id,
   output logic                                                   ckpt_full,
   input  logic                                                   ckpt_commit,
   input  logic                                                   recall_valid,
   input  logic [$clog2(NUM_CKPTS)-1:0]                           recall_id,
   output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0]           free_count
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
   ,
   output logic                                                   dbl_free_err
`endif
);

   localparam int unsigned DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned HP_W  = IDX_W + 1;
   localparam int unsigned T_W   = $clog2(NUM_PHYS_REGS);
   localparam logic [HP_W-1:0] PTR_ONE = HP_W'(1);

   logic [T_W-1:0]  entry_q [DEPTH];
   logic [T_W-1:0]  entry_d [DEPTH];
   logic [HP_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [HP_W-1:0] n_req, n_free, rd_ptr, wr_ptr, snap_ptr, recall_head;
   logic            ckpt_block, ckpt_accept;

   // Grant: popcount, readiness and compacted per-lane tag selection.
   always_comb begin
      n_req      = HP_W'(count_below(32'(alloc_req), ALLOC_WIDTH));
      free_count = tail_q - head_q;
      // A same-cycle commit frees the oldest slot, which is the slot a full ring's make writes.
      ckpt_block = ckpt_make && ckpt_full && !ckpt_commit;
      alloc_ready = !recall_valid && (free_count >= n_req) && !ckpt_block;
      ckpt_accept = ckpt_make && alloc_ready;
      snap_ptr    = head_q + HP_W'(count_below(32'(alloc_req), 32'(ckpt_lane) + 32'd1));
      rd_ptr      = head_q;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         rd_ptr = head_q + HP_W'(count_below(32'(alloc_req), i));
         if (alloc_ready && alloc_req[i]) begin
            alloc_tags[i] = entry_q[rd_ptr[IDX_W-1:0]];
         end else begin
            alloc_tags[i] = '0;
         end
      end
   end

   // Free write-back at the tail and next head/tail pointers.
   always_comb begin
      entry_d = entry_q;
      wr_ptr  = tail_q;
      for (int i = 0; i < FREE_WIDTH; i++) begin
         if (free_valid[i]) begin
            entry_d[wr_ptr[IDX_W-1:0]] = free_tags[i];
            wr_ptr = wr_ptr + PTR_ONE;
         end else begin
            wr_ptr = wr_ptr;
         end
      end
      tail_d = wr_ptr;
      n_free = wr_ptr - tail_q;

      if (recall_valid) begin
         head_d = recall_head;
      end else if (alloc_ready) begin
         head_d = head_q + n_req;
      end else begin
         head_d = head_q;
      end
   end

   // Free-list storage and pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= HP_W'(DEPTH);
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= T_W'(NUM_ARCH_REGS + i);
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         entry_q <= entry_d;
      end
   end

   free_list_ckpt_ring #(
      .NUM_CKPTS (NUM_CKPTS),
      .SNAP_W    (HP_W)
   ) u_ring (
      .clk         (clk),
      .reset       (reset),
      .make        (ckpt_accept),
      .commit      (ckpt_commit),
      .recall      (recall_valid),
      .recall_id   (recall_id),
      .make_snap   (snap_ptr),
      .ckpt_id     (ckpt_id),
      .ckpt_full   (ckpt_full),
      .recall_snap (recall_head)
   );

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
   logic [NUM_PHYS_REGS-1:0] in_list_q, in_list_d;
   logic                     dbl_free_err_q, dbl_free_err_d;
   logic                     err_hit;
   logic [HP_W:0]            live_after;
   logic [HP_W-1:0]          live_cnt;
   logic [IDX_W-1:0]         rel_idx;

   // Membership tracking and error detection for returned tags.
   always_comb begin
      in_list_d = in_list_q;
      err_hit   = 1'b0;
      live_cnt  = tail_d - head_d;
      rel_idx   = '0;
      for (int i = 0; i < FREE_WIDTH; i++) begin
         if (free_valid[i] && in_list_q[free_tags[i]]) begin
            err_hit = 1'b1;
         end else begin
            err_hit = err_hit;
         end
         for (int j = 0; j < FREE_WIDTH; j++) begin
            if ((j < i) && free_valid[i] && free_valid[j] && (free_tags[j] == free_tags[i])) begin
               err_hit = 1'b1;
            end else begin
               err_hit = err_hit;
            end
         end
      end
      live_after = {1'b0, free_count} + {1'b0, n_free};
      if (live_after > (HP_W+1)'(DEPTH)) begin
         err_hit = 1'b1;
      end else begin
         err_hit = err_hit;
      end

      if (recall_valid) begin
         // Rebuild from the ring contents between the restored head and the new tail.
         in_list_d = '0;
         for (int j = 0; j < DEPTH; j++) begin
            rel_idx = IDX_W'(j) - head_d[IDX_W-1:0];
            if ({1'b0, rel_idx} < live_cnt) begin
               in_list_d[entry_d[j]] = 1'b1;
            end else begin
               in_list_d = in_list_d;
            end
         end
      end else begin
         for (int i = 0; i < ALLOC_WIDTH; i++) begin
            if (alloc_ready && alloc_req[i]) begin
               in_list_d[alloc_tags[i]] = 1'b0;
            end else begin
               in_list_d = in_list_d;
            end
         end
         for (int i = 0; i < FREE_WIDTH; i++) begin
            if (free_valid[i]) begin
               in_list_d[free_tags[i]] = 1'b1;
            end else begin
               in_list_d = in_list_d;
            end
         end
      end
      dbl_free_err_d = dbl_free_err_q | err_hit;
   end

   // Membership vector and sticky error flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_PHYS_REGS; i++) begin
            in_list_q[i] <= (i >= NUM_ARCH_REGS);
         end
         dbl_free_err_q <= 1'b0;
      end else begin
         in_list_q      <= in_list_d;
         dbl_free_err_q <= dbl_free_err_d;
      end
   end

   assign dbl_free_err = dbl_free_err_q;
`endif

endmodule
